// File: rtl/ranged_counter_pkg.sv
// Shared constants and range helpers for the ranged counter bank.
package ranged_counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;
  localparam int unsigned LOAD_CH_W = 4;

  // Reset value of channel i: LO + i, clamped to HI.
  function automatic int unsigned reset_value(int unsigned i, int unsigned lo, int unsigned hi);
    return ((lo + i) > hi) ? hi : (lo + i);
  endfunction

  // True when v lies inside [lo, hi].
  function automatic logic in_range(int unsigned v, int unsigned lo, int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ranged_counter_bank_if.sv
// Request/response bundle between a controller and the counter bank.
interface ranged_counter_bank_if #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned WIDTH  = 8
);
  import ranged_counter_pkg::*;

  logic [NUM_CH-1:0]       inc;
  logic [NUM_CH-1:0]       dec;
  logic                    load;
  logic [LOAD_CH_W-1:0]    load_ch;
  logic [WIDTH-1:0]        load_val;
  logic                    err_clr;
  logic [NUM_CH*WIDTH-1:0] value;
  logic [NUM_CH-1:0]       at_lo;
  logic [NUM_CH-1:0]       at_hi;
  logic [NUM_CH-1:0]       edge_evt;
  logic                    range_err;

  modport master (
    output inc, dec, load, load_ch, load_val, err_clr,
    input  value, at_lo, at_hi, edge_evt, range_err
  );

  modport slave (
    input  inc, dec, load, load_ch, load_val, err_clr,
    output value, at_lo, at_hi, edge_evt, range_err
  );

endinterface

// File: rtl/ranged_counter.sv
// One range-bounded up/down counter channel with wrap/saturate handling.
module ranged_counter
  import ranged_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LO    = 1,
  parameter int unsigned HI    = 5,
  parameter int unsigned MODE  = MODE_WRAP,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load_hit,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             edge_evt,
  output logic             reject_c
);

  localparam int unsigned      EXT_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(reset_value(IDX, LO, HI));
  localparam logic [EXT_W-1:0] LO_X  = EXT_W'(LO);
  localparam logic [EXT_W-1:0] HI_X  = EXT_W'(HI);

  logic [EXT_W-1:0] value_x;
  logic [EXT_W-1:0] up_x;
  logic [EXT_W-1:0] dn_x;
  logic [WIDTH-1:0] next_value;
  logic             next_edge;

  // Step arithmetic one bit wider so HI at the top of the range cannot overflow.
  assign value_x = {1'b0, value};
  assign up_x    = value_x + EXT_W'(1);
  assign dn_x    = value_x - EXT_W'(1);

  // Load beats stepping; inc and dec together cancel.
  always_comb begin
    next_value = value;
    next_edge  = 1'b0;
    reject_c   = 1'b0;
    if (load_hit) begin
      if (in_range(32'(load_val), LO, HI)) begin
        next_value = load_val;
      end else begin
        reject_c = 1'b1;
      end
    end else if (inc ^ dec) begin
      if (inc) begin
        if (up_x > HI_X) begin
          next_edge  = 1'b1;
          next_value = (MODE == MODE_SAT) ? value : WIDTH'(LO_X);
        end else begin
          next_value = WIDTH'(up_x);
        end
      end else begin
        if (value_x <= LO_X) begin
          next_edge  = 1'b1;
          next_value = (MODE == MODE_SAT) ? value : WIDTH'(HI_X);
        end else begin
          next_value = WIDTH'(dn_x);
        end
      end
    end
  end

  // Channel value and boundary pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value    <= RST_V;
      edge_evt <= 1'b0;
    end else begin
      value    <= next_value;
      edge_evt <= next_edge;
    end
  end

endmodule

// File: rtl/ranged_counter_bank.sv
// Bank of independent range-bounded counters with a shared sticky load-error flag.
module ranged_counter_bank
  import ranged_counter_pkg::*;
#(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LO     = 1,
  parameter int unsigned HI     = 5,
  parameter int unsigned MODE   = MODE_WRAP
) (
  input logic                  clk,
  input logic                  rst_n,
  ranged_counter_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);

  logic [NUM_CH-1:0] load_hit;
  logic [NUM_CH-1:0] reject_c;
  logic [NUM_CH-1:0] edge_q;
  logic [WIDTH-1:0]  ch_value [NUM_CH];
  logic              oob_c;
  logic              range_err_q;

  // Decode the load target; a channel index past the bank is a reject.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      load_hit[i] = bus.load && (bus.load_ch == LOAD_CH_W'(i));
    end
  end

  assign oob_c = bus.load && (32'(bus.load_ch) >= NUM_CH);

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    ranged_counter #(
      .WIDTH (WIDTH),
      .LO    (LO),
      .HI    (HI),
      .MODE  (MODE),
      .IDX   (g)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (bus.inc[g]),
      .dec      (bus.dec[g]),
      .load_hit (load_hit[g]),
      .load_val (bus.load_val),
      .value    (ch_value[g]),
      .edge_evt (edge_q[g]),
      .reject_c (reject_c[g])
    );
  end

  // Sticky reject flag; a new reject outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_q <= 1'b0;
    end else if ((|reject_c) || oob_c) begin
      range_err_q <= 1'b1;
    end else if (bus.err_clr) begin
      range_err_q <= 1'b0;
    end
  end

  // Pack channel values and derive boundary flags from the registered values.
  always_comb begin
    bus.value = '0;
    bus.at_lo = '0;
    bus.at_hi = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      bus.value[i*WIDTH +: WIDTH] = ch_value[i];
      bus.at_lo[i]                = (ch_value[i] == LO_V);
      bus.at_hi[i]                = (ch_value[i] == HI_V);
    end
  end

  assign bus.edge_evt  = edge_q;
  assign bus.range_err = range_err_q;

endmodule
